// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Tile buffer and sequencer ahead of the systolic delay lines.
//               Loads a tile of DEPTH vectors over a valid/ready port. On
//               start, it streams the tile one vector per cycle, then drives
//               FLUSH_LEN zero vectors and pulses done.
//               Optional macro SYSTOLIC_FEEDER_REPLAY_EN adds a replay input.
//               When replay is high on the done edge, the tile is kept for
//               another stream.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
    parameter int DATA_SIZE = 16,
    parameter int SIZE      = 4,
    parameter int DEPTH     = 4,
    parameter int FLUSH_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_SIZE*SIZE-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      start,
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
    input  logic                      replay,
`endif
    output logic [DATA_SIZE*SIZE-1:0] bus_out,
    output logic                      out_valid,
    output logic                      done
);

    localparam int c_vec_w = DATA_SIZE * SIZE;
    localparam int c_max_n = (DEPTH > FLUSH_LEN) ? DEPTH : FLUSH_LEN;
    localparam int c_cnt_w = $clog2(c_max_n + 1);
    localparam int c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_mem_n = 1 << c_aw;

    localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_load_last  = c_cnt_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_flush_last = c_cnt_w'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

    localparam logic [1:0] c_st_load   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_stream = 2'd2;
    localparam logic [1:0] c_st_flush  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [1:0]         w_done_state;
    logic [c_cnt_w-1:0] r_load_cnt;
    logic [c_cnt_w-1:0] w_load_cnt_next;
    logic [c_cnt_w-1:0] r_idx;
    logic [c_cnt_w-1:0] w_idx_next;
    logic [c_cnt_w-1:0] r_flush_cnt;
    logic [c_cnt_w-1:0] w_flush_cnt_next;
    logic [c_vec_w-1:0] w_bus_next;
    logic               w_valid_next;
    logic               w_done_next;
    logic               w_accept;
    logic [c_vec_w-1:0] r_mem [0:c_mem_n-1];

    // Ready depends only on the state and reset, never on in_valid.
    assign in_ready = rst_n && (r_state == c_st_load);
    assign w_accept = in_valid && in_ready;

    // Where the FSM lands after done: back to LOAD, or to WAIT to replay the held tile.
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
    assign w_done_state = replay ? c_st_wait : c_st_load;
`else
    assign w_done_state = c_st_load;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_load;
            r_load_cnt  <= '0;
            r_idx       <= '0;
            r_flush_cnt <= '0;
            bus_out     <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_load_cnt  <= w_load_cnt_next;
            r_idx       <= w_idx_next;
            r_flush_cnt <= w_flush_cnt_next;
            bus_out     <= w_bus_next;
            out_valid   <= w_valid_next;
            done        <= w_done_next;
        end
    end

    // Tile storage; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_load_cnt[c_aw-1:0]] <= in_data;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_load: begin
                if (w_accept && (r_load_cnt == c_load_last)) begin
                    w_state_next = c_st_wait;
                end
            end
            c_st_wait: begin
                if (start) begin
                    w_state_next = c_st_stream;
                end
            end
            c_st_stream: begin
                if (r_idx == c_depth) begin
                    w_state_next = (FLUSH_LEN == 0) ? w_done_state : c_st_flush;
                end
            end
            c_st_flush: begin
                if (r_flush_cnt == c_flush_last) begin
                    w_state_next = w_done_state;
                end
            end
            default: w_state_next = c_st_load;
        endcase
    end

    // Counter updates and next values of the registered outputs.
    always_comb begin
        w_load_cnt_next  = r_load_cnt;
        w_idx_next       = r_idx;
        w_flush_cnt_next = r_flush_cnt;
        w_bus_next       = '0;
        w_valid_next     = 1'b0;
        w_done_next      = 1'b0;
        case (r_state)
            c_st_load: begin
                if (w_accept) begin
                    w_load_cnt_next = (r_load_cnt == c_load_last) ? '0 : r_load_cnt + c_one;
                end
            end
            c_st_wait: begin
                if (start) begin
                    w_bus_next   = r_mem[0];
                    w_valid_next = 1'b1;
                    w_idx_next   = c_one;
                end
            end
            c_st_stream: begin
                // r_idx reaches DEPTH only after the last vector has been presented.
                if (r_idx == c_depth) begin
                    w_idx_next  = '0;
                    w_done_next = (FLUSH_LEN == 0);
                end else begin
                    w_bus_next   = r_mem[r_idx[c_aw-1:0]];
                    w_valid_next = 1'b1;
                    w_idx_next   = r_idx + c_one;
                end
            end
            c_st_flush: begin
                if (r_flush_cnt == c_flush_last) begin
                    w_flush_cnt_next = '0;
                    w_done_next      = 1'b1;
                end else begin
                    w_flush_cnt_next = r_flush_cnt + c_one;
                end
            end
            default: begin
                w_load_cnt_next = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Bench for systolic_feeder. A per-cycle vector table drives a
//               DEPTH=4/FLUSH_LEN=4 instance. A short hand-written sequence
//               drives a second instance built with DEPTH=1 and FLUSH_LEN=0.
//               Rows that exercise replay are included only when
//               SYSTOLIC_FEEDER_REPLAY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int VW = 64;

    typedef struct {
        logic          rst_n;
        logic          valid;
        logic [VW-1:0] data;
        logic          start;
        logic          replay;
        logic          exp_ready;
        logic          exp_valid;
        logic [VW-1:0] exp_bus;
        logic          exp_done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [VW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          start;
    logic          replay;
    logic [VW-1:0] bus_out;
    logic          out_valid;
    logic          done;

    logic [VW-1:0] in_data1;
    logic          in_valid1;
    logic          in_ready1;
    logic          start1;
    logic [VW-1:0] bus_out1;
    logic          out_valid1;
    logic          done1;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    systolic_feeder #(.DATA_SIZE(16), .SIZE(4), .DEPTH(4), .FLUSH_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
        .replay    (replay),
`endif
        .bus_out   (bus_out),
        .out_valid (out_valid),
        .done      (done)
    );

    systolic_feeder #(.DATA_SIZE(16), .SIZE(4), .DEPTH(1), .FLUSH_LEN(0)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .start     (start1),
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
        .replay    (1'b0),
`endif
        .bus_out   (bus_out1),
        .out_valid (out_valid1),
        .done      (done1)
    );

    function automatic void add(input logic r, input logic v, input logic [VW-1:0] d,
                                input logic s, input logic rp, input logic er,
                                input logic ev, input logic [VW-1:0] eb, input logic ed);
        vec_t x;
        x.rst_n = r; x.valid = v; x.data = d; x.start = s; x.replay = rp;
        x.exp_ready = er; x.exp_valid = ev; x.exp_bus = eb; x.exp_done = ed;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input int row, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Full tile pass from LOAD: stream the tile, flush, then done.
    // The flush row at index rp_at carries the replay bit; ready_at_done is
    // the expected in_ready during the done cycle.
    task automatic add_stream(input logic [VW-1:0] t [4], input logic s_hold,
                              input logic rp, input logic ready_at_done);
        for (int i = 0; i < 4; i++) add(1, 0, '0, s_hold, 0, 0, 1, t[i], 0);
        for (int i = 0; i < 4; i++) add(1, 0, '0, 0, (i == 3) ? rp : 1'b0, 0, 0, '0, 0);
        add(1, 0, '0, 0, 0, ready_at_done, 0, '0, 1);
    endtask

    logic [VW-1:0] t1 [4];
    logic [VW-1:0] t2 [4];
    logic [VW-1:0] t3 [4];
    logic [VW-1:0] t4 [4];
    logic [VW-1:0] t5 [4];

    initial begin
        t1 = '{64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008,
               64'h0009_000A_000B_000C, 64'h000D_000E_000F_0010};
        t2 = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
               64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
        t3 = '{64'h0A0A_0B0B_0C0C_0D0D, 64'h1A1A_1B1B_1C1C_1D1D,
               64'h2A2A_2B2B_2C2C_2D2D, 64'h3A3A_3B3B_3C3C_3D3D};
        t4 = '{64'hC001_C002_C003_C004, 64'hC005_C006_C007_C008,
               64'hC009_C00A_C00B_C00C, 64'hC00D_C00E_C00F_C010};
        t5 = '{64'h7000_0001_7000_0002, 64'h7000_0003_7000_0004,
               64'h7000_0005_7000_0006, 64'h7000_0007_7000_0008};

        // Reset held: in_ready low, outputs zero, a valid beat is not taken.
        add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, '0, 0);

        // Back-to-back load, start pulse, stream, flush, done with in_ready=1.
        for (int i = 0; i < 4; i++) add(1, 1, t1[i], 0, 0, 1, 0, '0, 0);
        add(1, 0, '0, 1, 0, 0, 0, '0, 0);
        add_stream(t1, 0, 0, 1);
        add(1, 0, '0, 0, 0, 1, 0, '0, 0);

        // Toggling in_valid with start held during LOAD; start is ignored there.
        for (int i = 0; i < 4; i++) begin
            add(1, 1, t2[i], 1, 0, 1, 0, '0, 0);
            if (i < 3) add(1, 0, 64'h0BAD_0BAD_0BAD_0BAD, 1, 0, 1, 0, '0, 0);
        end
        add(1, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0, 0, '0, 0);
        add(1, 0, '0, 1, 0, 0, 0, '0, 0);
        add_stream(t2, 0, 0, 1);
        add(1, 0, '0, 0, 0, 1, 0, '0, 0);

        // start held from before the last beat: WAIT lasts one cycle.
        for (int i = 0; i < 4; i++) add(1, 1, t3[i], 1, 0, 1, 0, '0, 0);
        add(1, 0, '0, 1, 0, 0, 0, '0, 0);
        add_stream(t3, 1, 0, 1);
        add(1, 0, '0, 0, 0, 1, 0, '0, 0);

        // Reset during the second stream cycle aborts the tile; done never follows.
        for (int i = 0; i < 4; i++) add(1, 1, t4[i], 0, 0, 1, 0, '0, 0);
        add(1, 0, '0, 1, 0, 0, 0, '0, 0);
        add(1, 0, '0, 0, 0, 0, 1, t4[0], 0);
        add(0, 0, '0, 0, 0, 0, 1, t4[1], 0);
        for (int i = 0; i < 10; i++) add(1, 0, '0, 0, 0, 1, 0, '0, 0);

`ifdef SYSTOLIC_FEEDER_REPLAY_EN
        // Replay: the tile streams twice with no reload, and in_ready stays low in between.
        for (int i = 0; i < 4; i++) add(1, 1, t5[i], 0, 0, 1, 0, '0, 0);
        add(1, 0, '0, 1, 0, 0, 0, '0, 0);
        add_stream(t5, 0, 1, 0);
        add(1, 1, 64'h0123_4567_89AB_CDEF, 1, 0, 0, 0, '0, 0);
        add_stream(t5, 0, 0, 1);
        add(1, 0, '0, 0, 0, 1, 0, '0, 0);
`endif

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; start = 1'b0; replay = 1'b0;
        in_data1 = '0; in_valid1 = 1'b0; start1 = 1'b0;
        repeat (2) @(posedge clk);

        // Apply each row in its own cycle and compare before the next rising edge.
        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rst_n = vecs[r].rst_n; in_valid = vecs[r].valid; in_data = vecs[r].data;
            start = vecs[r].start; replay = vecs[r].replay;
            #1;
            chk("in_ready", r, {63'd0, in_ready}, {63'd0, vecs[r].exp_ready});
            chk("out_valid", r, {63'd0, out_valid}, {63'd0, vecs[r].exp_valid});
            chk("bus_out", r, bus_out, vecs[r].exp_bus);
            chk("done", r, {63'd0, done}, {63'd0, vecs[r].exp_done});
        end

        // DEPTH=1, FLUSH_LEN=0: a single stream cycle, then done on the next cycle.
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0; replay = 1'b0; rst_n = 1'b1;
        in_valid1 = 1'b1; in_data1 = 64'hAAAA_BBBB_CCCC_DDDD;
        #1 chk("d1_ready_load", 0, {63'd0, in_ready1}, 64'd1);
        @(negedge clk);
        in_valid1 = 1'b0; start1 = 1'b1;
        #1 chk("d1_ready_wait", 1, {63'd0, in_ready1}, 64'd0);
        chk("d1_valid_wait", 1, {63'd0, out_valid1}, 64'd0);
        @(negedge clk);
        start1 = 1'b0;
        #1 chk("d1_valid_stream", 2, {63'd0, out_valid1}, 64'd1);
        chk("d1_bus_stream", 2, bus_out1, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("d1_done_stream", 2, {63'd0, done1}, 64'd0);
        @(negedge clk);
        #1 chk("d1_done", 3, {63'd0, done1}, 64'd1);
        chk("d1_valid_done", 3, {63'd0, out_valid1}, 64'd0);
        chk("d1_bus_done", 3, bus_out1, 64'd0);
        chk("d1_ready_done", 3, {63'd0, in_ready1}, 64'd1);
        @(negedge clk);
        #1 chk("d1_done_clear", 4, {63'd0, done1}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
